uart_rx_adv: RTL



---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_rx_adv_if.sv | 26 ++
 rtl/uart_bit_sampler.sv | 62 ++++++
 rtl/uart_rx_adv.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART receiver family.
package uart_pkg;

    // Parity mode encodings; values 5..7 are treated as ParNone by the receiver.
    typedef enum logic [2:0] {
        ParNone  = 3'd0,
        ParOdd   = 3'd1,
        ParEven  = 3'd2,
        ParMark  = 3'd3,
        ParSpace = 3'd4
    } parity_e;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StParity  = 3'd3,
        StStop    = 3'd4,
        StBrkWait = 3'd5
    } state_e;

    // Stop-bit count encoding.
    typedef enum logic {
        Stop1 = 1'b0,
        Stop2 = 1'b1
    } stop_e;

    localparam logic [3:0] MinDataBits = 4'd5;
    localparam logic [3:0] MaxDataBits = 4'd9;

    // Clamp a requested data-bit count into MinDataBits..max_bits.
    function automatic logic [3:0] clamp_databits(input logic [3:0] req,
                                                  input logic [3:0] max_bits);
        if (req < MinDataBits) begin
            return MinDataBits;
        end
        if (req > max_bits) begin
            return max_bits;
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_adv_if.sv
// Output side of the receiver: holding register, status flags and valid/ready handshake.
interface uart_rx_adv_if #(
    parameter int unsigned DW = 9
) ();

    logic [DW-1:0] dout;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_error;
    logic          frame_error;
    logic          overrun;
    logic          break_tick;

    // Receiver side.
    modport master (
        output dout, rx_valid, parity_error, frame_error, overrun, break_tick,
        input  rx_ready
    );

    // Consumer side.
    modport slave (
        input  dout, rx_valid, parity_error, frame_error, overrun, break_tick,
        output rx_ready
    );

endinterface

// File: rtl/uart_bit_sampler.sv
// Input synchroniser, oversample counter and 3-sample majority vote for one bit period.
module uart_bit_sampler #(
    parameter int unsigned OS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic s_tick,
    input  logic run,            // counter runs only while a frame is in progress
    output logic rxs,
    output logic bit_val,
    output logic resolve_pulse,
    output logic bit_end_pulse
);

    localparam int unsigned SW = (OS > 2) ? $clog2(OS) : 1;
    localparam logic [SW-1:0] SLo   = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] SMid  = SW'(OS / 2);
    localparam logic [SW-1:0] SHi   = SW'(OS / 2 + 1);
    localparam logic [SW-1:0] SLast = SW'(OS - 1);

    logic [1:0]    sync_q;
    logic [SW-1:0] s_q;
    logic          samp_lo_q;
    logic          samp_mid_q;

    // Two-flop synchroniser, idle-high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxs = sync_q[1];

    // Tick counter within the bit plus capture of the first two vote samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= '0;
            samp_lo_q  <= 1'b1;
            samp_mid_q <= 1'b1;
        end else if (!run) begin
            s_q <= '0;
        end else if (s_tick) begin
            s_q <= (s_q == SLast) ? '0 : s_q + SW'(1);
            if (s_q == SLo) begin
                samp_lo_q <= rxs;
            end
            if (s_q == SMid) begin
                samp_mid_q <= rxs;
            end
        end
    end

    // Third sample is the live value, so the vote resolves on the SHi tick itself.
    assign bit_val       = (samp_lo_q & samp_mid_q) | (samp_lo_q & rxs) | (samp_mid_q & rxs);
    assign resolve_pulse = run && s_tick && (s_q == SHi);
    assign bit_end_pulse = run && s_tick && (s_q == SLast);

endmodule

// File: rtl/uart_rx_adv.sv
// UART receiver: majority-voted bits, 5..9 data bits, parity, break detection and a
// one-entry valid/ready holding register with overrun flag.
module uart_rx_adv
    import uart_pkg::*;
#(
    parameter int unsigned OS = 16,
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    input  logic          s_tick,
    input  logic [3:0]    databits,
    input  logic          stopbits,
    input  logic [2:0]    paritymode,
    uart_rx_adv_if.master bus
);

    localparam logic [3:0] MaxBits = (DW < 9) ? 4'(DW) : MaxDataBits;

    logic rxs;
    logic bit_val;
    logic resolve;
    logic bit_end;
    logic run;

    state_e        state_q;
    logic [3:0]    n_q;
    logic [3:0]    nbits_q;
    parity_e       par_q;
    stop_e         stops_q;
    logic          stop_n_q;      // set once the first stop bit has resolved
    logic [DW-1:0] data_q;
    logic          perr_q;
    logic          ferr_q;
    logic          any_one_q;     // any data/parity/stop majority seen as 1

    logic [DW-1:0] dout_q;
    logic          valid_q;
    logic          perr_out_q;
    logic          ferr_out_q;
    logic          overrun_q;
    logic          break_q;

    assign run = (state_q == StStart) || (state_q == StData) ||
                 (state_q == StParity) || (state_q == StStop);

    uart_bit_sampler #(
        .OS(OS)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .s_tick       (s_tick),
        .run          (run),
        .rxs          (rxs),
        .bit_val      (bit_val),
        .resolve_pulse(resolve),
        .bit_end_pulse(bit_end)
    );

    // Frame FSM, shift register, holding register and handshake, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            nbits_q    <= MaxDataBits;
            par_q      <= ParNone;
            stops_q    <= Stop1;
            stop_n_q   <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            any_one_q  <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            break_q <= 1'b0;

            if (valid_q && bus.rx_ready) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_q <= StStart;
                    end
                end

                StStart: begin
                    if (resolve && bit_val) begin
                        state_q <= StIdle;
                    end else if (bit_end) begin
                        state_q   <= StData;
                        n_q       <= '0;
                        data_q    <= '0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                        any_one_q <= 1'b0;
                        stop_n_q  <= 1'b0;
                        nbits_q   <= clamp_databits(databits, MaxBits);
                        par_q     <= (paritymode > 3'd4) ? ParNone : parity_e'(paritymode);
                        stops_q   <= stop_e'(stopbits);
                    end
                end

                StData: begin
                    if (resolve) begin
                        data_q    <= data_q | (DW'(bit_val) << n_q);
                        any_one_q <= any_one_q | bit_val;
                    end
                    if (bit_end) begin
                        if (n_q == nbits_q - 4'd1) begin
                            state_q <= (par_q == ParNone) ? StStop : StParity;
                        end else begin
                            n_q <= n_q + 4'd1;
                        end
                    end
                end

                StParity: begin
                    if (resolve) begin
                        any_one_q <= any_one_q | bit_val;
                        unique case (par_q)
                            ParOdd:   perr_q <= ~(^data_q ^ bit_val);
                            ParEven:  perr_q <= ^data_q ^ bit_val;
                            ParMark:  perr_q <= ~bit_val;
                            ParSpace: perr_q <= bit_val;
                            default:  perr_q <= 1'b0;
                        endcase
                    end
                    if (bit_end) begin
                        state_q <= StStop;
                    end
                end

                StStop: begin
                    if (resolve) begin
                        if (stop_n_q || (stops_q == Stop1)) begin
                            // Complete at the last stop resolve so the next start is seen early.
                            if (!(any_one_q | bit_val)) begin
                                break_q <= 1'b1;
                                state_q <= StBrkWait;
                            end else begin
                                dout_q     <= data_q;
                                perr_out_q <= perr_q;
                                ferr_out_q <= ferr_q | ~bit_val;
                                valid_q    <= 1'b1;
                                if (valid_q) begin
                                    overrun_q <= ~bus.rx_ready;
                                end
                                state_q <= StIdle;
                            end
                        end else begin
                            ferr_q    <= ferr_q | ~bit_val;
                            any_one_q <= any_one_q | bit_val;
                            stop_n_q  <= 1'b1;
                        end
                    end
                end

                StBrkWait: begin
                    if (rxs) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_valid     = valid_q;
    assign bus.parity_error = perr_out_q;
    assign bus.frame_error  = ferr_out_q;
    assign bus.overrun      = overrun_q;
    assign bus.break_tick   = break_q;

endmodule
